// File: rtl/fcc_way_arbiter_if.sv
// fcc_way_arbiter_if: per-way scheduler/executer handshakes, CE and PHY bus.
// The master modport is the arbiter side; slave is the scheduler/executer/PHY side.
interface fcc_way_arbiter_if #(
    parameter int WAY_NUM = 4
) ();
    logic [WAY_NUM-1:0]    i_sched_valid;
    logic [WAY_NUM-1:0]    o_sched_ready;
    logic [WAY_NUM-1:0]    o_exec_valid;
    logic [WAY_NUM-1:0]    i_exec_ready;
    logic [WAY_NUM-1:0]    i_io_busy;
    logic [WAY_NUM-1:0]    o_keep_wait;
    logic [WAY_NUM-1:0]    o_owner;
    logic [WAY_NUM-1:0]    i_ce_n_w;
    logic [WAY_NUM-1:0]    o_ce_n;
    logic [46*WAY_NUM-1:0] i_bus_w;
    logic [45:0]           o_bus;

    modport master (
        input  i_sched_valid,
        input  i_exec_ready,
        input  i_io_busy,
        input  i_ce_n_w,
        input  i_bus_w,
        output o_sched_ready,
        output o_exec_valid,
        output o_keep_wait,
        output o_owner,
        output o_ce_n,
        output o_bus
    );

    modport slave (
        output i_sched_valid,
        output i_exec_ready,
        output i_io_busy,
        output i_ce_n_w,
        output i_bus_w,
        input  o_sched_ready,
        input  o_exec_valid,
        input  o_keep_wait,
        input  o_owner,
        input  o_ce_n,
        input  o_bus
    );
endinterface

// File: rtl/fcc_way_arbiter.sv
// fcc_way_arbiter: per-way dispatch FSMs, serialised grant and PHY bus mux.
// Define FCC_WAY_ARB_RR_EN for round-robin grant; default is fixed priority.
module fcc_way_arbiter #(
    parameter int WAY_NUM = 4
) (
    input  logic              usr_clk,
    input  logic              usr_rst,
    fcc_way_arbiter_if.master arb
);
    localparam int BW = 46;
    localparam logic [BW-1:0] IDLE_WORD = {
        1'b1, 1'b0, 1'b0, 1'b1, 4'hf,
        1'b0, 4'hf, 1'b1, 32'h0
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOCK,
        FIN
    } way_st_e;

    way_st_e            st_q [WAY_NUM];
    way_st_e            st_d [WAY_NUM];
    logic [WAY_NUM-1:0] in_wait;
    logic [WAY_NUM-1:0] in_lock;
    logic [WAY_NUM-1:0] gnt;

    logic [WAY_NUM-1:0] sr_d, sr_q;
    logic [WAY_NUM-1:0] ev_d, ev_q;
    logic [WAY_NUM-1:0] kw_d, kw_q;
    logic [WAY_NUM-1:0] own_d, own_q;
    logic [WAY_NUM-1:0] busy_lsb;
    logic [WAY_NUM-1:0] ce_q;
    logic [BW-1:0]      bus_d, bus_q;

    always_comb begin
        in_wait = '0;
        in_lock = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            in_wait[w] = (st_q[w] == WAIT);
            in_lock[w] = (st_q[w] == LOCK);
        end
    end

`ifdef FCC_WAY_ARB_RR_EN
    localparam int PW = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    logic [PW-1:0] rr_ptr, rr_nxt;

    // Search starts at rr_ptr and wraps; first waiting way wins.
    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        gnt    = '0;
        rr_nxt = rr_ptr;
        if (!(|in_lock)) begin
            for (int i = 0; i < WAY_NUM; i++) begin
                idx = (int'(rr_ptr) + i) % WAY_NUM;
                if (!found && in_wait[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    rr_nxt   = (idx == WAY_NUM - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_nxt;
        end
    end
`else
    always_comb begin
        logic found;
        found = 1'b0;
        gnt   = '0;
        if (!(|in_lock)) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (!found && in_wait[w]) begin
                    found  = 1'b1;
                    gnt[w] = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        for (int w = 0; w < WAY_NUM; w++) begin
            st_d[w] = st_q[w];
            unique case (st_q[w])
                IDLE: if (arb.i_sched_valid[w]) st_d[w] = WAIT;
                WAIT: if (gnt[w])               st_d[w] = LOCK;
                LOCK: if (!arb.i_exec_ready[w]) st_d[w] = FIN;
                FIN:  if (arb.i_exec_ready[w])  st_d[w] = IDLE;
                default:                        st_d[w] = IDLE;
            endcase
        end
    end

    // exec_valid tracks the state being entered so it is high in LOCK itself.
    always_comb begin
        sr_d = '0;
        ev_d = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            ev_d[w] = (st_d[w] == LOCK);
            sr_d[w] = (st_q[w] == IDLE) && !arb.i_sched_valid[w];
        end
    end

    assign busy_lsb = arb.i_io_busy & (~arb.i_io_busy + WAY_NUM'(1));

    // A busy owner is never preempted; otherwise the lowest busy way takes over.
    always_comb begin
        if (|(own_q & arb.i_io_busy)) begin
            own_d = own_q;
        end else begin
            own_d = busy_lsb;
        end
    end

    always_comb begin
        kw_d = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            kw_d[w] = (|(arb.i_io_busy & ~(WAY_NUM'(1) << w)))
                    | (|(own_q & ~(WAY_NUM'(1) << w)));
        end
    end

    always_comb begin
        bus_d = IDLE_WORD;
        if (|own_d) begin
            bus_d = '0;
            for (int w = 0; w < WAY_NUM; w++) begin
                bus_d = bus_d | (arb.i_bus_w[BW*w +: BW] & {BW{own_d[w]}});
            end
        end
    end

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                st_q[w] <= IDLE;
            end
            sr_q  <= '0;
            ev_q  <= '0;
            kw_q  <= '0;
            own_q <= '0;
            ce_q  <= '1;
            bus_q <= IDLE_WORD;
        end else begin
            for (int w = 0; w < WAY_NUM; w++) begin
                st_q[w] <= st_d[w];
            end
            sr_q  <= sr_d;
            ev_q  <= ev_d;
            kw_q  <= kw_d;
            own_q <= own_d;
            ce_q  <= arb.i_ce_n_w;
            bus_q <= bus_d;
        end
    end

    assign arb.o_sched_ready = sr_q;
    assign arb.o_exec_valid  = ev_q;
    assign arb.o_keep_wait   = kw_q;
    assign arb.o_owner       = own_q;
    assign arb.o_ce_n        = ce_q;
    assign arb.o_bus         = bus_q;
endmodule
